rgb2hsv_stream: RTL and testbench

Parametrised streaming RGB-to-HSV converter, the successor to the fixed 8-bit converter in the image-processing chain. It accepts one pixel per clock and computes exactly rounded-down hue and saturation using bit-serial pipelined restoring dividers. It supports a configurable hue range (256 full-circle or 180 OpenCV-style) and ready/valid backpressure toward the downstream consumer. It sits between the camera capture path and the HSV thresholding/segmentation blocks.

---
 rtl/rgb2hsv_stream_if.sv | 23 ++
 rtl/rgb2hsv_stream.sv | 165 ++++++++++++++++
 tb/tb_rgb2hsv_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2hsv_stream_if.sv
// rgb2hsv_stream_if: pixel-in / HSV-out stream bundle with ready/valid on both sides.
interface rgb2hsv_stream_if #(
    parameter int DATA_W = 8,
    parameter int HUE_W  = 8
);
    logic              in_valid, in_ready, in_visual, in_done;
    logic [DATA_W-1:0] in_red, in_green, in_blue;
    logic              out_valid, out_ready, out_visual, out_done;
    logic [DATA_W-1:0] out_red, out_green, out_blue, out_saturation, out_brightness;
    logic [HUE_W-1:0]  out_hue;

    modport master (
        output in_valid, in_red, in_green, in_blue, in_visual, in_done, out_ready,
        input  in_ready, out_valid, out_red, out_green, out_blue, out_hue,
               out_saturation, out_brightness, out_visual, out_done
    );

    modport slave (
        input  in_valid, in_red, in_green, in_blue, in_visual, in_done, out_ready,
        output in_ready, out_valid, out_red, out_green, out_blue, out_hue,
               out_saturation, out_brightness, out_visual, out_done
    );
endinterface

// File: rtl/rgb2hsv_stream.sv
// rgb2hsv_stream: one-pixel-per-clock RGB to HSV with pipelined restoring dividers and a global stall.
module rgb2hsv_stream #(
    parameter int DATA_W    = 8,
    parameter int HUE_W     = 8,
    parameter int HUE_RANGE = 256
) (
    input logic clock,
    input logic reset_n,
    rgb2hsv_stream_if.slave bus
);
    localparam int Q   = HUE_W > DATA_W ? HUE_W : DATA_W;
    localparam int LAT = 4 + Q;
    localparam int NW  = DATA_W + 3;
    localparam int HW  = DATA_W + 3 + HUE_W;
    localparam int SW  = 2 * DATA_W;

    logic              en;
    logic [LAT-1:0]    v_p, vis_p, done_p;
    logic [DATA_W-1:0] r_p [LAT];
    logic [DATA_W-1:0] g_p [LAT];
    logic [DATA_W-1:0] b_p [LAT];
    logic [DATA_W-1:0] mx, mn, s1_max, s1_min, s2_dif, s2_max, dif;
    logic [1:0]        idx, s1_idx;
    logic [NW-1:0]     n_c, s2_n, de, re, ge, be;
    logic [HW-1:0]     hrem [Q];
    logic [HW-1:0]     hdv [Q];
    logic [HW-1:0]     hrem_n [Q];
    logic [SW-1:0]     srem [Q];
    logic [SW-1:0]     sdv [Q];
    logic [SW-1:0]     srem_n [Q];
    logic [HUE_W-1:0]  hq [Q+1];
    logic [HUE_W-1:0]  hq_n [Q];
    logic [DATA_W-1:0] sq [Q+1];
    logic [DATA_W-1:0] sq_n [Q];
    logic [DATA_W-1:0] bri [Q+1];
    logic [Q:0]        z;
    logic [HUE_W-1:0]  hue_o;
    logic [DATA_W-1:0] sat_o, bri_o;
    logic              r_max, b_max;

    assign en = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;

    // Max priority R, then B, then G; the index selects the hue sector.
    always_comb begin
        r_max = bus.in_red >= bus.in_green && bus.in_red >= bus.in_blue;
        b_max = !r_max && bus.in_blue >= bus.in_green;
        mx    = r_max ? bus.in_red : b_max ? bus.in_blue : bus.in_green;
        mn    = (bus.in_red <= bus.in_green && bus.in_red <= bus.in_blue) ? bus.in_red :
                (bus.in_green <= bus.in_blue ? bus.in_green : bus.in_blue);
        idx   = r_max ? 2'd0 : b_max ? 2'd2 : 2'd1;
    end

    always_comb begin
        dif = s1_max - s1_min;
        de  = NW'(dif);
        re  = NW'(r_p[0]);
        ge  = NW'(g_p[0]);
        be  = NW'(b_p[0]);
        n_c = s1_idx == 2'd0 ? (ge >= be ? ge - be : (de << 2) + (de << 1) - (be - ge)) :
              s1_idx == 2'd1 ? (de << 1) + be - re : (de << 2) + re - ge;
    end

    // Divider step j resolves quotient bit Q-1-j; bits above a divider's width are idle steps.
    always_comb begin
        for (int j = 0; j < Q; j++) begin
            hrem_n[j] = hrem[j];
            hq_n[j]   = hq[j];
            srem_n[j] = srem[j];
            sq_n[j]   = sq[j];
            if (Q - 1 - j < HUE_W && hrem[j] >= (hdv[j] << (Q - 1 - j))) begin
                hrem_n[j] = hrem[j] - (hdv[j] << (Q - 1 - j));
                hq_n[j]   = hq[j] | (HUE_W'(1) << (Q - 1 - j));
            end
            if (Q - 1 - j < DATA_W && srem[j] >= (sdv[j] << (Q - 1 - j))) begin
                srem_n[j] = srem[j] - (sdv[j] << (Q - 1 - j));
                sq_n[j]   = sq[j] | (DATA_W'(1) << (Q - 1 - j));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v_p    <= '0;
            vis_p  <= '0;
            done_p <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_p[i] <= '0;
                g_p[i] <= '0;
                b_p[i] <= '0;
            end
            s1_max <= '0;
            s1_min <= '0;
            s1_idx <= '0;
            s2_dif <= '0;
            s2_max <= '0;
            s2_n   <= '0;
            for (int i = 0; i < Q; i++) begin
                hrem[i] <= '0;
                hdv[i]  <= '0;
                srem[i] <= '0;
                sdv[i]  <= '0;
            end
            for (int i = 0; i <= Q; i++) begin
                hq[i]  <= '0;
                sq[i]  <= '0;
                bri[i] <= '0;
            end
            z     <= '0;
            hue_o <= '0;
            sat_o <= '0;
            bri_o <= '0;
        end else if (en) begin
            v_p    <= {v_p[LAT-2:0], bus.in_valid};
            vis_p  <= {vis_p[LAT-2:0], bus.in_visual};
            done_p <= {done_p[LAT-2:0], bus.in_done};
            r_p[0] <= bus.in_red;
            g_p[0] <= bus.in_green;
            b_p[0] <= bus.in_blue;
            for (int i = 1; i < LAT; i++) begin
                r_p[i] <= r_p[i-1];
                g_p[i] <= g_p[i-1];
                b_p[i] <= b_p[i-1];
            end
            s1_max  <= mx;
            s1_min  <= mn;
            s1_idx  <= idx;
            s2_dif  <= dif;
            s2_max  <= s1_max;
            s2_n    <= n_c;
            hrem[0] <= HW'(s2_n) * HW'(HUE_RANGE);
            hdv[0]  <= (HW'(s2_dif) << 2) + (HW'(s2_dif) << 1);
            srem[0] <= (SW'(s2_dif) << DATA_W) - SW'(s2_dif);
            sdv[0]  <= SW'(s2_max);
            hq[0]   <= '0;
            sq[0]   <= '0;
            bri[0]  <= s2_max;
            z       <= {z[Q-1:0], s2_dif == '0};
            for (int j = 0; j < Q - 1; j++) begin
                hrem[j+1] <= hrem_n[j];
                hdv[j+1]  <= hdv[j];
                srem[j+1] <= srem_n[j];
                sdv[j+1]  <= sdv[j];
            end
            for (int j = 0; j < Q; j++) begin
                hq[j+1]  <= hq_n[j];
                sq[j+1]  <= sq_n[j];
                bri[j+1] <= bri[j];
            end
            hue_o <= z[Q] ? '0 : hq[Q];
            sat_o <= z[Q] ? '0 : sq[Q];
            bri_o <= bri[Q];
        end
    end

    assign bus.out_valid      = v_p[LAT-1];
    assign bus.out_visual     = vis_p[LAT-1];
    assign bus.out_done       = done_p[LAT-1];
    assign bus.out_red        = r_p[LAT-1];
    assign bus.out_green      = g_p[LAT-1];
    assign bus.out_blue       = b_p[LAT-1];
    assign bus.out_hue        = hue_o;
    assign bus.out_saturation = sat_o;
    assign bus.out_brightness = bri_o;
endmodule

// File: tb/tb_rgb2hsv_stream.sv
// tb_rgb2hsv_stream: scoreboard bench for two converters (hue range 256 and 180) sharing one stimulus stream.
module tb_rgb2hsv_stream;
    typedef struct {
        int r, g, b, vis, done, hue, sat, v;
    } px_t;

    logic clock = 0;
    logic reset_n = 0;
    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 0;
    px_t  qa[$];
    px_t  qb[$];

    always #5 clock = ~clock;

    rgb2hsv_stream_if #(.DATA_W(8), .HUE_W(8)) bus_a ();
    rgb2hsv_stream_if #(.DATA_W(8), .HUE_W(8)) bus_b ();

    rgb2hsv_stream #(.DATA_W(8), .HUE_W(8), .HUE_RANGE(256)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
    rgb2hsv_stream #(.DATA_W(8), .HUE_W(8), .HUE_RANGE(180)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    // Reference: hue as a fraction of the circle, sector offsets 0/2/4 in units of the chroma.
    function automatic int hue_of(int r, int g, int b, int range);
        int mx, mn, c, n;
        mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
        mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
        c = mx - mn;
        if (c == 0) return 0;
        if (r >= g && r >= b) n = (g - b + 6 * c) % (6 * c);
        else if (b >= g) n = 4 * c + r - g;
        else n = 2 * c + b - r;
        return (n * range) / (6 * c);
    endfunction

    function automatic int sat_of(int r, int g, int b);
        int mx, mn;
        mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
        mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
        return mx == 0 ? 0 : ((mx - mn) * 255) / mx;
    endfunction

    function automatic int max_of(int r, int g, int b);
        return r > g ? (r > b ? r : b) : (g > b ? g : b);
    endfunction

    task automatic cmp(input string nm, input px_t e, input px_t a);
        tests++;
        if (e.r != a.r || e.g != a.g || e.b != a.b || e.vis != a.vis || e.done != a.done ||
            e.hue != a.hue || e.sat != a.sat || e.v != a.v) begin
            fails++;
            $display("FAIL %s got rgb=%0d,%0d,%0d vis=%0d done=%0d h=%0d s=%0d v=%0d exp rgb=%0d,%0d,%0d vis=%0d done=%0d h=%0d s=%0d v=%0d",
                     nm, a.r, a.g, a.b, a.vis, a.done, a.hue, a.sat, a.v,
                     e.r, e.g, e.b, e.vis, e.done, e.hue, e.sat, e.v);
        end
    endtask

    task automatic check(input string nm, input bit ok, input int got, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input int r, input int g, input int b, input bit v, input bit vi, input bit d);
        bus_a.in_red = 8'(r); bus_a.in_green = 8'(g); bus_a.in_blue = 8'(b);
        bus_a.in_valid = v; bus_a.in_visual = vi; bus_a.in_done = d;
        bus_b.in_red = 8'(r); bus_b.in_green = 8'(g); bus_b.in_blue = 8'(b);
        bus_b.in_valid = v; bus_b.in_visual = vi; bus_b.in_done = d;
    endtask

    // ha < 0 selects the reference model; otherwise the given constants are the expectation.
    task automatic send(input int r, input int g, input int b, input bit vi, input bit d,
                        input int ha, input int hb, input int s, input int v);
        bit ok;
        int n = 0;
        drive(r, g, b, 1, vi, d);
        do begin
            @(negedge clock);
            ok = bus_a.in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("accept_timeout", 0, n, 200);
        if (ha < 0) begin
            qa.push_back('{r, g, b, vi, d, hue_of(r, g, b, 256), sat_of(r, g, b), max_of(r, g, b)});
            qb.push_back('{r, g, b, vi, d, hue_of(r, g, b, 180), sat_of(r, g, b), max_of(r, g, b)});
        end else begin
            qa.push_back('{r, g, b, vi, d, ha, s, v});
            qb.push_back('{r, g, b, vi, d, hb, s, v});
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", qa.size() == 0 && qb.size() == 0, qa.size() + qb.size(), 0);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_a"}, {bus_a.out_valid, bus_a.out_red, bus_a.out_green, bus_a.out_blue, bus_a.out_hue,
                           bus_a.out_saturation, bus_a.out_brightness, bus_a.out_visual, bus_a.out_done} == '0,
              int'(bus_a.out_valid), 0);
        check({nm, "_b"}, {bus_b.out_valid, bus_b.out_red, bus_b.out_hue, bus_b.out_saturation,
                           bus_b.out_brightness, bus_b.out_visual, bus_b.out_done} == '0,
              int'(bus_b.out_valid), 0);
    endtask

    initial begin
        bus_a.out_ready = 1;
        bus_b.out_ready = 1;
        forever begin
            @(posedge clock);
            #1;
            bus_a.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_b.out_ready = bus_a.out_ready;
        end
    end

    logic       prev_stall = 0;
    logic [0:0] dummy;
    logic [73:0] snap;
    px_t act;

    always @(negedge clock) begin
        if (reset_n) begin
            check("in_ready", bus_a.in_ready == !(bus_a.out_valid && !bus_a.out_ready),
                  int'(bus_a.in_ready), int'(!(bus_a.out_valid && !bus_a.out_ready)));
            if (prev_stall)
                check("stall_hold", snap == {bus_a.out_valid, bus_a.out_red, bus_a.out_green, bus_a.out_blue,
                                             bus_a.out_hue, bus_a.out_saturation, bus_a.out_brightness,
                                             bus_a.out_visual, bus_a.out_done, bus_b.out_hue},
                      int'(bus_a.out_hue), int'(snap[49:42]));
            prev_stall = bus_a.out_valid && !bus_a.out_ready;
            snap = {bus_a.out_valid, bus_a.out_red, bus_a.out_green, bus_a.out_blue, bus_a.out_hue,
                    bus_a.out_saturation, bus_a.out_brightness, bus_a.out_visual, bus_a.out_done, bus_b.out_hue};
            if (bus_a.out_valid && bus_a.out_ready) begin
                act = '{bus_a.out_red, bus_a.out_green, bus_a.out_blue, bus_a.out_visual, bus_a.out_done,
                        bus_a.out_hue, bus_a.out_saturation, bus_a.out_brightness};
                if (qa.size() == 0) check("unexpected_a", 0, act.hue, -1);
                else cmp("pix_a", qa.pop_front(), act);
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                act = '{bus_b.out_red, bus_b.out_green, bus_b.out_blue, bus_b.out_visual, bus_b.out_done,
                        bus_b.out_hue, bus_b.out_saturation, bus_b.out_brightness};
                if (qb.size() == 0) check("unexpected_b", 0, act.hue, -1);
                else cmp("pix_b", qb.pop_front(), act);
            end
        end else prev_stall = 0;
    end

    initial begin
        int cnt;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_out");
        check("reset_in_ready", bus_a.in_ready == 1'b1, int'(bus_a.in_ready), 1);
        reset_n = 1;

        send(255, 0, 0, 0, 0, 0, 0, 255, 255);
        send(0, 255, 0, 1, 0, 85, 60, 255, 255);
        send(0, 0, 255, 0, 1, 170, 120, 255, 255);
        send(255, 0, 255, 1, 1, 213, 150, 255, 255);
        send(200, 100, 50, 0, 0, 14, 10, 191, 200);
        send(128, 128, 128, 0, 0, 0, 0, 0, 128);
        send(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        drive(10, 200, 30, 1, 1, 1);
        qa.push_back('{10, 200, 30, 1, 1, hue_of(10, 200, 30, 256), sat_of(10, 200, 30), 200});
        qb.push_back('{10, 200, 30, 1, 1, hue_of(10, 200, 30, 180), sat_of(10, 200, 30), 200});
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        cnt = 1;
        while (!bus_a.out_valid && cnt < 40) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        check("latency", cnt == 12 && bus_a.out_visual && bus_a.out_done, cnt, 12);
        @(posedge clock);
        #1;
        check("single_cycle", bus_a.out_valid == 1'b0, int'(bus_a.out_valid), 0);

        rand_rdy = 1;
        for (int i = 0; i < 64; i++) begin
            int r, g, b;
            r = $urandom_range(0, 255);
            g = ($urandom_range(0, 7) == 0) ? r : $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? g : $urandom_range(0, 255);
            send(r, g, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1, 0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        drain();
        rand_rdy = 0;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, -1, -1, 0, 0);
        reset_n = 0;
        @(posedge clock);
        #1;
        check_zero("midreset_out");
        qa.delete();
        qb.delete();
        reset_n = 1;
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < 4; i++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 1, -1, -1, 0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
